// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: datapath widths, condition-code type and encoder.
package lc3_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = cc_t'(3'b010);

  // Signed classification of a word into exactly one of N/Z/P.
  function automatic cc_t cc_from_word(input logic [DATA_W-1:0] word);
    cc_t cc;
    cc.n = word[DATA_W-1];
    cc.z = (word == '0);
    cc.p = !cc.n && !cc.z;
    return cc;
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// 3-to-8 binary-to-one-hot decoder used for register write steering.
module decoder_3_to_8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = 8'(1) << sel;
  end

endmodule

// File: rtl/lc3_reg_file.sv
// LC-3 register file: R0-R7 with one write and two read ports, plus NZP.
module lc3_reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_reg,
  input  logic [2:0]        dr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  input  logic              ld_cc,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              n,
  output logic              z,
  output logic              p
);

  import lc3_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [7:0]        wsel;
  cc_t               cc;
  cc_t               cc_next;

  decoder_3_to_8 u_dec (
    .sel    (dr),
    .onehot (wsel)
  );

  // Classify the bus word as signed; exactly one flag is set.
  always_comb begin
    cc_next   = CC_RESET;
    cc_next.n = bus_in[DATA_W-1];
    cc_next.z = (bus_in == '0);
    cc_next.p = !cc_next.n && !cc_next.z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      cc <= CC_RESET;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (ld_reg && wsel[i]) begin
          regs[i] <= bus_in;
        end
      end
      if (ld_cc) begin
        cc <= cc_next;
      end
    end
  end

  // Read ports; with BYPASS the in-flight write is forwarded to a matching port.
  always_comb begin
    sr1_out = regs[sr1];
    sr2_out = regs[sr2];
    if (BYPASS && ld_reg && (dr == sr1)) begin
      sr1_out = bus_in;
    end
    if (BYPASS && ld_reg && (dr == sr2)) begin
      sr2_out = bus_in;
    end
  end

  always_comb begin
    n = cc.n;
    z = cc.z;
    p = cc.p;
  end

endmodule

// File: tb/tb_lc3_reg_file.sv
// Randomised self-checking bench for lc3_reg_file, both BYPASS settings.
module tb_lc3_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [15:0] bus_in;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        ld_cc;
  logic [15:0] sr1_out0, sr2_out0, sr1_out1, sr2_out1;
  logic        n0, z0, p0, n1, z1, p1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [8];
  logic [2:0]  cc_m;
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  lc3_reg_file #(.DATA_W(16), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ld_reg(ld_reg), .dr(dr), .bus_in(bus_in),
    .sr1(sr1), .sr2(sr2), .ld_cc(ld_cc),
    .sr1_out(sr1_out0), .sr2_out(sr2_out0), .n(n0), .z(z0), .p(p0)
  );

  lc3_reg_file #(.DATA_W(16), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ld_reg(ld_reg), .dr(dr), .bus_in(bus_in),
    .sr1(sr1), .sr2(sr2), .ld_cc(ld_cc),
    .sr1_out(sr1_out1), .sr2_out(sr2_out1), .n(n1), .z(z1), .p(p1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] nzp_of(input logic [15:0] w);
    if ($signed(w) < 0) return 3'b100;
    if (w == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  // Apply one cycle of inputs, check reads before the edge and NZP after it.
  task automatic drive(input logic r, input logic lr, input logic [2:0] d,
                       input logic [15:0] b, input logic [2:0] s1,
                       input logic [2:0] s2, input logic lc);
    logic [15:0] e1, e2;
    rst = r; ld_reg = lr; dr = d; bus_in = b; sr1 = s1; sr2 = s2; ld_cc = lc;
    #1;
    if (model_valid) begin
      check("sr1_stored", sr1_out0, mem[s1]);
      check("sr2_stored", sr2_out0, mem[s2]);
      e1 = (lr && d == s1) ? b : mem[s1];
      e2 = (lr && d == s2) ? b : mem[s2];
      check("sr1_bypass", sr1_out1, e1);
      check("sr2_bypass", sr2_out1, e2);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      cc_m = 3'b010;
      model_valid = 1'b1;
    end else begin
      if (lr) mem[d] = b;
      if (lc) cc_m = nzp_of(b);
    end
    #1;
    if (model_valid) begin
      check("nzp0", 16'({n0, z0, p0}), 16'(cc_m));
      check("nzp1", 16'({n1, z1, p1}), 16'(cc_m));
    end
  endtask

  initial begin
    rst = 1'b1; ld_reg = 1'b0; dr = 3'd0; bus_in = 16'h0; sr1 = 3'd0; sr2 = 3'd0; ld_cc = 1'b0;
    #1;

    // Reset held two cycles while a write and CC load are requested.
    drive(1, 1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1);
    drive(1, 1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 0);
    check("reset_nzp_const", 16'({n0, z0, p0}), 16'h0002);

    // Fill R0..R7, then sweep both read ports.
    for (int i = 0; i < 8; i++) drive(0, 1, 3'(i), 16'h1110 + 16'(i), 3'd0, 3'd7, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 0);
      check("sweep_const", sr1_out0, 16'h1110 + 16'(i));
    end

    // Read-during-write on R5.
    drive(0, 1, 3'd5, 16'h00AA, 3'd5, 3'd5, 0);
    rst = 0; ld_reg = 1; dr = 3'd5; bus_in = 16'h0055; sr1 = 3'd5; sr2 = 3'd0; ld_cc = 0;
    #1;
    check("rdw_old_const", sr1_out0, 16'h00AA);
    check("rdw_byp_const", sr1_out1, 16'h0055);
    drive(0, 1, 3'd5, 16'h0055, 3'd5, 3'd0, 0);
    drive(0, 0, 3'd0, 16'h0, 3'd5, 3'd5, 0);
    check("rdw_new_const", sr1_out0, 16'h0055);

    // CC encoding corners.
    drive(0, 0, 3'd0, 16'h8000, 3'd0, 3'd1, 1);
    check("cc_8000", 16'({n0, z0, p0}), 16'h0004);
    drive(0, 0, 3'd0, 16'h0000, 3'd0, 3'd1, 1);
    check("cc_0000", 16'({n0, z0, p0}), 16'h0002);
    drive(0, 0, 3'd0, 16'h7FFF, 3'd0, 3'd1, 1);
    check("cc_7fff", 16'({n0, z0, p0}), 16'h0001);
    drive(0, 0, 3'd0, 16'hFFFF, 3'd0, 3'd1, 1);
    check("cc_ffff", 16'({n0, z0, p0}), 16'h0004);

    // Independence of ld_cc and ld_reg.
    drive(0, 0, 3'd2, 16'h0001, 3'd2, 3'd3, 1);
    drive(0, 1, 3'd2, 16'h0000, 3'd2, 3'd3, 0);
    drive(0, 0, 3'd0, 16'h0, 3'd2, 3'd3, 0);
    check("indep_r2", sr1_out0, 16'h0000);
    check("indep_nzp", 16'({n0, z0, p0}), 16'h0001);

    // Reset in the same cycle as in-flight writes and CC load.
    drive(0, 1, 3'd1, 16'h1234, 3'd1, 3'd6, 0);
    drive(0, 1, 3'd6, 16'h5678, 3'd1, 3'd6, 1);
    drive(1, 1, 3'd1, 16'h9ABC, 3'd1, 3'd6, 1);
    drive(0, 0, 3'd0, 16'h0, 3'd1, 3'd6, 0);
    check("mid_rst_r1", sr1_out0, 16'h0000);
    check("mid_rst_r6", sr2_out0, 16'h0000);
    check("mid_rst_nzp", 16'({n0, z0, p0}), 16'h0002);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] b;
      case ($urandom_range(0, 3))
        0: b = 16'h0000;
        1: b = 16'h8000;
        default: b = 16'($urandom);
      endcase
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom), b,
            3'($urandom), 3'($urandom), 1'($urandom));
      check("onehot", 16'(int'(n1) + int'(z1) + int'(p1)), 16'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
